// File: rtl/dec_scan_n.sv
// dec_scan_n -- registered N-to-2^N one-hot decoder with a dwell-timed auto-scan.
//
// Direct mode registers onehot(w). Scan mode walks the one-hot output through
// 0..OUTS-1, holding each position for DWELL cycles, starting from w. Every
// output is a flop, so the decoder has no input-to-output combinational path.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   enable in   1      1 = active, 0 = outputs low, index/dwell frozen
//   mode   in   1      0 = direct, 1 = scan
//   load   in   1      scan only: force index to w and restart the dwell
//   w      in   N      select value / scan start / load value
//   y      out  OUTS   one-hot, y[k] = 1 when index == k (declared [0:OUTS-1])
//   sel    out  N      index currently driving y
//   wrap   out  1      one-cycle pulse as the scan index steps OUTS-1 -> 0
module dec_scan_n #(
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      w,
    output logic [0:(2**N)-1] y,
    output logic [N-1:0]      sel,
    output logic              wrap
);
    localparam int OUTS = 2 ** N;
    localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            wrap_q, wrap_d;
    logic [0:OUTS-1] y_q, y_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        y_d     = '0;

        if (!enable) begin
            // Frozen: index and dwell keep their values, outputs go quiet.
            state_d = ST_OFF;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            idx_d   = w;
            dwell_d = '0;
            for (int k = 0; k < OUTS; k++) y_d[k] = (w == N'(k));
        end else begin
            state_d = ST_SCAN;
            // Entering scan (from OFF or DIRECT) always restarts at w; a frozen
            // index is deliberately not resumed. Load wins over the dwell step,
            // which also suppresses a coincident wrap pulse.
            if (state_q != ST_SCAN || load) begin
                idx_d   = w;
                dwell_d = '0;
            end else if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                idx_d   = idx_q + 1'b1;
                wrap_d  = (idx_q == {N{1'b1}});
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
            for (int k = 0; k < OUTS; k++) y_d[k] = (idx_d == N'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    assign y    = y_q;
    assign sel  = idx_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_dec_scan_n.sv
// Bench for dec_scan_n: one N=4/DWELL=4 instance and one N=2/DWELL=1 instance
// share clock, reset and control. A time-based reference model predicts each
// instance: in scan, position = (start + cycles_since_start / DWELL) mod OUTS.
module tb_dec_scan_n;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0]  w4 = '0;
    logic [1:0]  w2 = '0;
    logic [0:15] y4;
    logic [3:0]  sel4;
    logic        wrap4;
    logic [0:3]  y2;
    logic [1:0]  sel2;
    logic        wrap2;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    dec_scan_n #(.N(4), .DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load),
        .w(w4), .y(y4), .sel(sel4), .wrap(wrap4)
    );
    dec_scan_n #(.N(2), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load),
        .w(w2), .y(y2), .sel(sel2), .wrap(wrap2)
    );

    // Reference model state, index 0 -> dut4, index 1 -> dut2.
    int outs[2] = '{16, 4};
    int dwl[2]  = '{4, 1};
    int m_base[2], m_t[2], m_sel[2];
    bit m_on[2], m_scan[2], m_wrap[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_base[k] = 0; m_t[k] = 0; m_sel[k] = 0;
            m_on[k] = 0; m_scan[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input int wv);
        m_wrap[k] = 0;
        if (!enable) begin
            m_on[k] = 0;
            m_scan[k] = 0;
        end else if (!mode) begin
            m_on[k] = 1;
            m_scan[k] = 0;
            m_sel[k] = wv;
        end else begin
            m_on[k] = 1;
            if (!m_scan[k] || load) begin
                m_base[k] = wv;
                m_t[k] = 0;
            end else begin
                m_t[k]++;
                if ((m_t[k] % dwl[k]) == 0 &&
                    ((m_base[k] + m_t[k] / dwl[k]) % outs[k]) == 0)
                    m_wrap[k] = 1;
            end
            m_scan[k] = 1;
            m_sel[k] = (m_base[k] + m_t[k] / dwl[k]) % outs[k];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_model();
        logic [0:15] e4;
        logic [0:3]  e2;
        e4 = '0;
        e2 = '0;
        if (m_on[0]) e4[m_sel[0]] = 1'b1;
        if (m_on[1]) e2[m_sel[1]] = 1'b1;
        chk("y4",    64'(y4),    64'(e4));
        chk("sel4",  64'(sel4),  64'(m_sel[0]));
        chk("wrap4", 64'(wrap4), 64'(m_wrap[0]));
        chk("y2",    64'(y2),    64'(e2));
        chk("sel2",  64'(sel2),  64'(m_sel[1]));
        chk("wrap2", 64'(wrap2), 64'(m_wrap[1]));
        chk("pop4",  64'($countones(y4) <= 1), 64'd1);
        chk("pop2",  64'($countones(y2) <= 1), 64'd1);
    endtask

    // One clock: model consumes the inputs present at the edge, outputs are
    // checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(0, int'(w4));
            model_edge(1, int'(w2));
        end
        #1;
        check_model();
    endtask

    logic [3:0] seq2 [4];
    int nw;

    initial begin
        seq2 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        model_reset();

        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_y4",   64'(y4),   64'h0);
        chk("rst_sel4", 64'(sel4), 64'h0);
        chk("rst_wrap", 64'(wrap4), 64'h0);
        step();
        rst = 1'b0;
        step();

        // Direct mode
        enable = 1'b1; mode = 1'b0; w4 = 4'd5; w2 = 2'd1;
        step();
        chk("dir_y5",   64'(y4),   64'h0400);
        chk("dir_sel5", 64'(sel4), 64'd5);
        w4 = 4'd15;
        step();
        chk("dir_y15", 64'(y4), 64'h0001);
        enable = 1'b0;
        step();
        chk("dir_off_y", 64'(y4), 64'h0);

        // Scan entry at 14, two wraps within 128 cycles after entry
        enable = 1'b1; mode = 1'b1; w4 = 4'd14; w2 = 2'd2;
        step();
        chk("scan_entry_sel", 64'(sel4), 64'd14);
        nw = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (wrap4) nw++;
        end
        chk("scan_wrap_cnt", 64'(nw), 64'd2);

        // Load at dwell count 2 while index = 7
        mode = 1'b0; step();
        mode = 1'b1; w4 = 4'd7; step();
        step(); step();
        load = 1'b1; w4 = 4'd3;
        step();
        chk("load_sel", 64'(sel4), 64'd3);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("load_hold", 64'(sel4), 64'd3);
        end
        step();
        chk("load_next", 64'(sel4), 64'd4);

        // Load coinciding with the 15 -> 0 wrap step
        load = 1'b1; w4 = 4'd15; step();
        load = 1'b0; step(); step(); step();
        load = 1'b1; w4 = 4'd9;
        step();
        chk("ldwrap_sel",  64'(sel4),  64'd9);
        chk("ldwrap_wrap", 64'(wrap4), 64'd0);

        // Held load stalls the scan on w
        w4 = 4'd6;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stall_sel", 64'(sel4), 64'd6);
        end

        // Disable for 10 cycles, then re-enable restarts at w
        load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("off_y",   64'(y4),   64'h0);
            chk("off_sel", 64'(sel4), 64'd6);
        end
        enable = 1'b1; w4 = 4'd2;
        step();
        chk("reen_sel", 64'(sel4), 64'd2);
        step(); step();

        // Asynchronous reset mid-scan, between clock edges
        rst = 1'b1;
        #1;
        chk("arst_y4",   64'(y4),    64'h0);
        chk("arst_sel4", 64'(sel4),  64'h0);
        chk("arst_wrap", 64'(wrap4), 64'h0);
        chk("arst_y2",   64'(y2),    64'h0);
        model_reset();
        step();
        rst = 1'b0;

        // DWELL=1 instance: one-hot walk every cycle, wrap every 4 cycles
        enable = 1'b1; mode = 1'b1; w2 = 2'd0; w4 = 4'd0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("d1_y",    64'(y2),    64'(seq2[i % 4]));
            chk("d1_wrap", 64'(wrap2), 64'((i % 4 == 0) && (i > 0)));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            mode   = ($urandom_range(0, 3) != 0);
            load   = ($urandom_range(0, 15) == 0);
            w4     = 4'($urandom);
            w2     = 2'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
